// File: rtl/stream_cache_read_gate_if.sv
// Writer-token link and read-request link of the cache read gate.
// master drives tokens/req_ready; slave is the gate itself.
interface stream_cache_read_gate_if #(
  parameter int LEN_BITS  = 32,
  parameter int MAX_BURST = 4096,
  parameter int BUF_BYTES = 1 << 20
);
  localparam int OFF_W = $clog2(BUF_BYTES);
  localparam int RL_W  = $clog2(MAX_BURST) + 1;

  logic [LEN_BITS-1:0] len_data;
  logic                len_valid;
  logic                len_ready;
  logic                req_valid;
  logic                req_ready;
  logic [OFF_W-1:0]    req_offset;
  logic [RL_W-1:0]     req_len;

  modport master (
    output len_data, len_valid, req_ready,
    input  len_ready, req_valid, req_offset, req_len
  );

  modport slave (
    input  len_data, len_valid, req_ready,
    output len_ready, req_valid, req_offset, req_len
  );
endinterface

// File: rtl/stream_cache_read_gate.sv
// Turns committed-byte tokens into bounded ring-buffer read requests.
// Requests never cross the ring end and are held stable until taken.
module stream_cache_read_gate #(
  parameter int LEN_BITS    = 32,
  parameter int CREDIT_BITS = 40,
  parameter int MAX_BURST   = 4096,
  parameter int BUF_BYTES   = 1 << 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  output logic [CREDIT_BITS-1:0] credit,
  stream_cache_read_gate_if.slave bus
);
  localparam int OFF_W = $clog2(BUF_BYTES);
  localparam int RL_W  = $clog2(MAX_BURST) + 1;

  localparam logic [CREDIT_BITS-1:0] LIMIT =
    {CREDIT_BITS{1'b1}} -
    CREDIT_BITS'({LEN_BITS{1'b1}});
  localparam logic [CREDIT_BITS-1:0] BURST_C =
    CREDIT_BITS'(MAX_BURST);
  localparam logic [CREDIT_BITS-1:0] BUF_C =
    CREDIT_BITS'(BUF_BYTES);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state, state_n;
  logic [CREDIT_BITS-1:0] credit_q, credit_n;
  logic [OFF_W-1:0]       offset, offset_n;
  logic [OFF_W-1:0]       roff, roff_n;
  logic [RL_W-1:0]        rlen, rlen_n;

  logic                   tok;
  logic                   hs;
  logic                   go;
  logic [CREDIT_BITS-1:0] add;
  logic [CREDIT_BITS-1:0] sub;
  logic [CREDIT_BITS-1:0] room;
  logic [CREDIT_BITS-1:0] pick;

  // Headroom check on registered credit; rst_n gates it low in reset.
  assign bus.len_ready = rst_n & (credit_q <= LIMIT);
  assign bus.req_valid = (state == REQ);
  assign bus.req_offset = roff;
  assign bus.req_len    = rlen;
  assign credit         = credit_q;

  assign tok = bus.len_valid & bus.len_ready;
  assign hs  = (state == REQ) & bus.req_ready;
  assign go  = (credit_q >= BURST_C) |
               (flush & (credit_q != '0));

  // Request size: limited by credit, burst and distance to ring end.
  always_comb begin
    room = BUF_C - CREDIT_BITS'(offset);
    pick = (credit_q < BURST_C) ? credit_q : BURST_C;
    if (room < pick) pick = room;
  end

  // Next-state, credit bookkeeping and request latching.
  always_comb begin
    state_n  = state;
    offset_n = offset;
    roff_n   = roff;
    rlen_n   = rlen;
    add      = tok ? CREDIT_BITS'(bus.len_data) : '0;
    sub      = hs ? CREDIT_BITS'(rlen) : '0;
    credit_n = credit_q + add - sub;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = REQ;
          roff_n  = offset;
          rlen_n  = pick[RL_W-1:0];
        end
      end
      REQ: begin
        if (bus.req_ready) begin
          state_n  = IDLE;
          offset_n = offset + OFF_W'(rlen);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset drops any pending request and all credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit_q <= '0;
      offset   <= '0;
      roff     <= '0;
      rlen     <= '0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      offset   <= offset_n;
      roff     <= roff_n;
      rlen     <= rlen_n;
    end
  end
endmodule
